alu_ctrl_encode_stage: RTL and testbench

- Decode-side counterpart of the EX-stage ALU signal decoder in the pipelined LEGv8 CPU.
- Encodes the ID-stage instruction opcode into the 3-bit ALU cntrl word plus operand-select and flag-enable bits.
- Registers them into the ID/EX pipeline boundary with stall/flush handling, a valid bit, and sticky illegal-opcode detection.
- Sole producer of EX-stage ALU control.

---
 rtl/alu_ctrl_encode_stage.sv | 124 ++++++++++++
 tb/tb_alu_ctrl_encode_stage.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_ctrl_encode_stage.sv
// ID-side ALU control encoder registered into the ID/EX boundary.
// Stall holds the boundary, flush bubbles it, and undecodable opcodes are flagged.
module alu_ctrl_encode_stage #(
  parameter int INSTR_W        = 32,
  parameter bit STICKY_ILLEGAL = 1'b1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [INSTR_W-1:0] instr,
  input  logic               id_valid,
  input  logic               stall,
  input  logic               flush,
  output logic               ex_valid,
  output logic [2:0]         ex_cntrl,
  output logic               ex_alu_src_imm,
  output logic [1:0]         ex_imm_sel,
  output logic               ex_set_flags,
  output logic               ex_shift,
  output logic               ex_illegal,
  output logic               illegal_seen
);

  typedef struct packed {
    logic       legal;
    logic [2:0] cntrl;
    logic       src_imm;
    logic [1:0] imm_sel;
    logic       set_flags;
    logic       shift;
  } dec_t;

  localparam logic [2:0] CNTRL_PASS = 3'b000;
  localparam logic [2:0] CNTRL_ADD  = 3'b010;
  localparam logic [2:0] CNTRL_SUB  = 3'b011;
  localparam logic [2:0] CNTRL_AND  = 3'b100;
  localparam logic [2:0] CNTRL_XOR  = 3'b110;

  localparam logic [1:0] IMM_NONE  = 2'b00;
  localparam logic [1:0] IMM_12    = 2'b01;
  localparam logic [1:0] IMM_DADDR = 2'b10;

  // The longest LEGv8 opcode field is 11 bits, so only instr[31:21] matters.
  function automatic dec_t decode(input logic [10:0] op);
    dec_t d;
    d         = '0;
    d.legal   = 1'b1;
    d.cntrl   = CNTRL_PASS;
    d.imm_sel = IMM_NONE;
    casez (op)
      11'b1001000100?: begin d.cntrl = CNTRL_ADD; d.src_imm = 1'b1; d.imm_sel = IMM_12; end
      11'b10101011000: begin d.cntrl = CNTRL_ADD; d.set_flags = 1'b1; end
      11'b11101011000: begin d.cntrl = CNTRL_SUB; d.set_flags = 1'b1; end
      11'b10001010000: d.cntrl = CNTRL_AND;
      11'b11001010000: d.cntrl = CNTRL_XOR;
      11'b11111000010,
      11'b11111000000: begin d.cntrl = CNTRL_ADD; d.src_imm = 1'b1; d.imm_sel = IMM_DADDR; end
      11'b1101001101?: d.shift = 1'b1;
      11'b10110100???,
      11'b01010100???,
      11'b000101?????: d.cntrl = CNTRL_PASS;
      default:         d.legal = 1'b0;
    endcase
    return d;
  endfunction

  // ID stage: combinational decode
  dec_t dec_p0;
  logic unused_low_bits;

  assign dec_p0          = decode(instr[INSTR_W-1 -: 11]);
  assign unused_low_bits = ^instr[INSTR_W-12:0];

  // ID/EX boundary registers
  logic       vld_p1;
  logic [2:0] cntrl_p1;
  logic       src_imm_p1;
  logic [1:0] imm_sel_p1;
  logic       set_flags_p1;
  logic       shift_p1;
  logic       illegal_p1;
  logic       seen_p1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_p1       <= 1'b0;
      cntrl_p1     <= CNTRL_PASS;
      src_imm_p1   <= 1'b0;
      imm_sel_p1   <= IMM_NONE;
      set_flags_p1 <= 1'b0;
      shift_p1     <= 1'b0;
      illegal_p1   <= 1'b0;
      seen_p1      <= 1'b0;
    end else if (flush || !stall) begin
      if (flush || !id_valid || !dec_p0.legal) begin
        vld_p1       <= 1'b0;
        cntrl_p1     <= CNTRL_PASS;
        src_imm_p1   <= 1'b0;
        imm_sel_p1   <= IMM_NONE;
        set_flags_p1 <= 1'b0;
        shift_p1     <= 1'b0;
        illegal_p1   <= !flush && id_valid && !dec_p0.legal;
        if (!flush && id_valid && !dec_p0.legal) seen_p1 <= 1'b1;
      end else begin
        vld_p1       <= 1'b1;
        cntrl_p1     <= dec_p0.cntrl;
        src_imm_p1   <= dec_p0.src_imm;
        imm_sel_p1   <= dec_p0.imm_sel;
        set_flags_p1 <= dec_p0.set_flags;
        shift_p1     <= dec_p0.shift;
        illegal_p1   <= 1'b0;
      end
    end
  end

  assign ex_valid       = vld_p1;
  assign ex_cntrl       = cntrl_p1;
  assign ex_alu_src_imm = src_imm_p1;
  assign ex_imm_sel     = imm_sel_p1;
  assign ex_set_flags   = set_flags_p1;
  assign ex_shift       = shift_p1;
  assign ex_illegal     = illegal_p1;
  assign illegal_seen   = STICKY_ILLEGAL ? seen_p1 : illegal_p1;

endmodule

// File: tb/tb_alu_ctrl_encode_stage.sv
// Scoreboard bench for alu_ctrl_encode_stage: a sticky and a non-sticky instance share
// one stimulus stream; expectations come from a prefix-table opcode model.
module tb_alu_ctrl_encode_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic [31:0] instr;
  logic        id_valid, stall, flush;

  logic       valid_s, src_s, flags_s, shift_s, ill_s, seen_s;
  logic [2:0] cntrl_s;
  logic [1:0] imm_s;
  logic       valid_n, src_n, flags_n, shift_n, ill_n, seen_n;
  logic [2:0] cntrl_n;
  logic [1:0] imm_n;

  alu_ctrl_encode_stage #(.INSTR_W(32), .STICKY_ILLEGAL(1'b1)) dut_s (
    .clk(clk), .reset_n(reset_n), .instr(instr), .id_valid(id_valid),
    .stall(stall), .flush(flush), .ex_valid(valid_s), .ex_cntrl(cntrl_s),
    .ex_alu_src_imm(src_s), .ex_imm_sel(imm_s), .ex_set_flags(flags_s),
    .ex_shift(shift_s), .ex_illegal(ill_s), .illegal_seen(seen_s));

  alu_ctrl_encode_stage #(.INSTR_W(32), .STICKY_ILLEGAL(1'b0)) dut_n (
    .clk(clk), .reset_n(reset_n), .instr(instr), .id_valid(id_valid),
    .stall(stall), .flush(flush), .ex_valid(valid_n), .ex_cntrl(cntrl_n),
    .ex_alu_src_imm(src_n), .ex_imm_sel(imm_n), .ex_set_flags(flags_n),
    .ex_shift(shift_n), .ex_illegal(ill_n), .illegal_seen(seen_n));

  // f = {valid, cntrl[2:0], src_imm, imm_sel[1:0], set_flags, shift, illegal}
  typedef struct packed {
    logic [9:0] f;
    logic       seen_s;
    logic       seen_n;
  } exp_t;

  exp_t q[$];
  exp_t m;
  int   checks   = 0;
  int   failures = 0;
  bit   mon_en   = 1'b0;

  // Opcode table: prefix width, prefix value, {cntrl, src_imm, imm_sel, set_flags, shift}
  int          pw  [12] = '{10, 11, 11, 11, 11, 11, 11, 11, 11, 8, 8, 6};
  logic [31:0] pat [12] = '{32'b1001000100, 32'b10101011000, 32'b11101011000,
                            32'b10001010000, 32'b11001010000, 32'b11111000010,
                            32'b11111000000, 32'b11010011011, 32'b11010011010,
                            32'b10110100, 32'b01010100, 32'b000101};
  logic [7:0]  fld [12] = '{8'b010_1_01_0_0, 8'b010_0_00_1_0, 8'b011_0_00_1_0,
                            8'b100_0_00_0_0, 8'b110_0_00_0_0, 8'b010_1_10_0_0,
                            8'b010_1_10_0_0, 8'b000_0_00_0_1, 8'b000_0_00_0_1,
                            8'b000_0_00_0_0, 8'b000_0_00_0_0, 8'b000_0_00_0_0};

  localparam logic [31:0] I_ADDI = 32'h91001401;
  localparam logic [31:0] I_SUBS = 32'hEB020023;
  localparam logic [31:0] I_EOR  = 32'hCA020023;
  localparam logic [31:0] I_LDUR = 32'hF8400020;
  localparam logic [31:0] I_AND  = 32'h8A020023;
  localparam logic [31:0] I_ADDS = 32'hAB020023;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  function automatic void ref_decode(input logic [31:0] i, output bit legal, output logic [7:0] fl);
    legal = 1'b0;
    fl    = 8'h00;
    for (int k = 0; k < 12; k++)
      if (!legal && ((i >> (32 - pw[k])) == pat[k])) begin
        legal = 1'b1;
        fl    = fld[k];
      end
  endfunction

  function automatic exp_t step(input exp_t cur, input logic [31:0] i,
                                input logic v, input logic s, input logic f);
    exp_t        n;
    bit          legal;
    logic [7:0]  fl;
    n = cur;
    if (f || (!s && !v)) begin
      n.f      = '0;
      n.seen_n = 1'b0;
    end else if (!s) begin
      ref_decode(i, legal, fl);
      if (legal) begin
        n.f      = {1'b1, fl, 1'b0};
        n.seen_n = 1'b0;
      end else begin
        n.f      = 10'b00000_00001;
        n.seen_s = 1'b1;
        n.seen_n = 1'b1;
      end
    end
    return n;
  endfunction

  task automatic cycle(input logic [31:0] i, input logic v, input logic s, input logic f);
    @(negedge clk);
    instr    = i;
    id_valid = v;
    stall    = s;
    flush    = f;
    m        = step(m, i, v, s, f);
    q.push_back(m);
    mon_en   = 1'b1;
  endtask

  function automatic logic [31:0] rand_instr();
    int          r;
    int          k;
    logic [31:0] low_mask;
    r = $urandom_range(0, 9);
    if (r < 7) begin
      k        = $urandom_range(0, 11);
      low_mask = (32'h1 << (32 - pw[k])) - 32'h1;
      return (pat[k] << (32 - pw[k])) | ($urandom & low_mask);
    end else if (r == 7) begin
      return 32'h0;
    end
    return $urandom;
  endfunction

  // Monitor: every cycle the boundary presents a new output word
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (mon_en) begin
        if (q.size() == 0) begin
          chk("queue_underflow", 32'd0, 32'd1);
        end else begin
          e = q.pop_front();
          chk("dut_sticky", {valid_s, cntrl_s, src_s, imm_s, flags_s, shift_s, ill_s, seen_s},
              {e.f, e.seen_s});
          chk("dut_nonsticky", {valid_n, cntrl_n, src_n, imm_n, flags_n, shift_n, ill_n, seen_n},
              {e.f, e.seen_n});
          chk("cntrl_code_used", 32'(cntrl_s == 3'b001 || cntrl_s == 3'b101 || cntrl_s == 3'b111), 0);
        end
      end
    end
  end

  initial begin
    m        = '0;
    reset_n  = 1'b1;
    instr    = I_ADDI;
    id_valid = 1'b1;
    stall    = 1'b0;
    flush    = 1'b0;
    #1 reset_n = 1'b0;
    #1;
    chk("reset_state", {valid_s, cntrl_s, src_s, imm_s, flags_s, shift_s, ill_s, seen_s}, 0);
    @(posedge clk);
    #1;
    chk("reset_hold_edge", {valid_s, cntrl_s, ill_s, seen_s, valid_n, seen_n}, 0);
    #1 reset_n = 1'b1;

    // single decode
    cycle(I_ADDI, 1'b1, 1'b0, 1'b0);
    @(posedge clk);
    #2;
    chk("addi_fields", {valid_s, cntrl_s, src_s, imm_s, flags_s}, {1'b1, 3'b010, 1'b1, 2'b01, 1'b0});

    // back-to-back
    cycle(I_SUBS, 1'b1, 1'b0, 1'b0);
    cycle(I_EOR,  1'b1, 1'b0, 1'b0);
    cycle(I_LDUR, 1'b1, 1'b0, 1'b0);
    @(posedge clk);
    #2;
    chk("ldur_imm_sel", {cntrl_s, flags_s, imm_s}, {3'b010, 1'b0, 2'b10});

    // stall holds SUBS while AND waits
    cycle(I_SUBS, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) cycle(I_AND, 1'b1, 1'b1, 1'b0);
    @(posedge clk);
    #2;
    chk("stall_hold", {valid_s, cntrl_s}, {1'b1, 3'b011});
    cycle(I_AND, 1'b1, 1'b0, 1'b0);
    @(posedge clk);
    #2;
    chk("and_after_stall", {valid_s, cntrl_s}, {1'b1, 3'b100});

    // flush beats stall
    cycle(I_ADDI, 1'b1, 1'b1, 1'b1);
    @(posedge clk);
    #2;
    chk("flush_priority", {valid_s, cntrl_s}, {1'b0, 3'b000});

    // illegal opcode then legal ADDS
    cycle(32'h0, 1'b1, 1'b0, 1'b0);
    @(posedge clk);
    #2;
    chk("illegal_flag", {ill_s, valid_s, seen_s, seen_n}, 4'b1011);
    cycle(I_ADDS, 1'b1, 1'b0, 1'b0);
    @(posedge clk);
    #2;
    chk("after_illegal", {valid_s, ill_s, seen_s, seen_n}, 4'b1010);

    // illegal under stall and under flush is discarded
    cycle(32'hFFFF_FFFF, 1'b1, 1'b1, 1'b0);
    cycle(32'hFFFF_FFFF, 1'b1, 1'b1, 1'b1);
    cycle(I_EOR, 1'b0, 1'b0, 1'b0);

    // asynchronous reset in the middle of a stall
    cycle(I_ADDI, 1'b1, 1'b0, 1'b0);
    cycle(I_AND,  1'b1, 1'b1, 1'b0);
    @(posedge clk);
    #3;
    mon_en = 1'b0;
    chk("pre_reset_valid", {valid_s, cntrl_s}, {1'b1, 3'b010});
    reset_n = 1'b0;
    #1;
    chk("async_reset_s", {valid_s, cntrl_s, src_s, imm_s, flags_s, shift_s, ill_s, seen_s}, 0);
    chk("async_reset_n", {valid_n, cntrl_n, src_n, imm_n, flags_n, shift_n, ill_n, seen_n}, 0);
    @(posedge clk);
    #1;
    chk("reset_mid_stall_hold", {valid_s, cntrl_s, seen_s}, 0);
    #1;
    m       = '0;
    reset_n = 1'b1;
    cycle(I_AND, 1'b1, 1'b0, 1'b0);

    // randomized traffic
    for (int k = 0; k < 400; k++)
      cycle(rand_instr(), ($urandom_range(0, 4) != 0), ($urandom_range(0, 4) == 0),
            ($urandom_range(0, 9) == 0));

    @(posedge clk);
    #3;
    chk("queue_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
